// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, FSM states, IR field positions.
// The optional single-step mode is controlled by the SINGLE_STEP_EN macro (adds the STEPWAIT state).
// Opcode classification helpers let the sequencer decide the execute path from the opcode alone.
package cpu_pkg;

  localparam int IRW_DEF = 32;
  localparam int OPW_DEF = 5;

  // Opcode encodings (ir[31:27])
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Register-select fields: Ra = ir[26:23], Rb = ir[22:19], Rc = ir[18:15]
  localparam int RA_LSB = 23;
  localparam int RB_LSB = 19;
  localparam int RC_LSB = 15;
  localparam int REG_W  = 4;

  // Control steps; RST and HALTED are the only states with Run=0
  typedef enum logic [3:0] {
    RST      = 4'd0,
    T0       = 4'd1,
    T1       = 4'd2,
    T2       = 4'd3,
    T3       = 4'd4,
    T4       = 4'd5,
    T5       = 4'd6,
    T6       = 4'd7,
    HALTED   = 4'd8
`ifdef SINGLE_STEP_EN
    ,
    STEPWAIT = 4'd9
`endif
  } state_t;

  // Two-operand ALU ops that write the result back to Ra
  function automatic logic is_alu(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  // Ops with a 64-bit result split into LO (T5) and HI (T6)
  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2, execute T3-T6, one control step per Clock; Moore strobes.
// Latency: ALU 6 clocks, MUL/DIV 7, NOP 4, HALT 4 to HALTED. Stop halts at the next instruction boundary.
// SINGLE_STEP_EN adds a Step input; each instruction then waits in STEPWAIT for a Step pulse.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int IRW = IRW_DEF,
  parameter int OPW = OPW_DEF
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic [IRW-1:0] ir,
  input  logic           Stop,
`ifdef SINGLE_STEP_EN
  input  logic           Step,
`endif
  output logic           PCout,
  output logic           MARin,
  output logic           IncPC,
  output logic           Zin,
  output logic           ZLOout,
  output logic           ZHIout,
  output logic           PCin,
  output logic           Read,
  output logic           MDRin,
  output logic           MDRout,
  output logic           IRin,
  output logic           Yin,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic           HIin,
  output logic           LOin,
  output logic [OPW-1:0] alu_op,
  output logic           Run
);

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic           stop_q, stop_d;
  logic           boundary;
  logic [OPW-1:0] ir_op;

  assign ir_op = ir[IRW-1 -: OPW];

  // Register-select fields are consumed by the datapath, not by the sequencer
  logic unused_ir_fields;
  assign unused_ir_fields = ^{ir[RA_LSB +: REG_W], ir[RB_LSB +: REG_W],
                              ir[RC_LSB +: REG_W], ir[RC_LSB-1:0]};

  // Where a completed instruction goes next when no halt is pending
`ifdef SINGLE_STEP_EN
  localparam state_t NEXT_INSTR = STEPWAIT;
`else
  localparam state_t NEXT_INSTR = T0;
`endif

  // Next state, opcode capture and sticky stop request
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    stop_d   = stop_q | Stop;
    boundary = 1'b0;
    case (state_q)
      RST: boundary = 1'b1;
      T0:  state_d = T1;
      T1:  state_d = T2;
      T2:  state_d = T3;
      T3: begin
        // IR only becomes valid on the T2->T3 edge, so T3 decodes ir directly
        // and op_q holds the opcode for T4..T6.
        op_d = ir_op;
        if (is_alu(ir_op) || is_muldiv(ir_op)) begin
          state_d = T4;
        end else if (ir_op == OP_HALT) begin
          state_d = HALTED;
          stop_d  = 1'b0;
        end else begin
          boundary = 1'b1;  // NOP and unknown opcodes
        end
      end
      T4:  state_d = T5;
      T5: begin
        if (is_muldiv(op_q)) state_d = T6;
        else                 boundary = 1'b1;
      end
      T6:  boundary = 1'b1;
      HALTED: stop_d = 1'b0;
`ifdef SINGLE_STEP_EN
      STEPWAIT: begin
        if (stop_d) begin
          state_d = HALTED;
          stop_d  = 1'b0;
        end else if (Step) begin
          state_d = T0;
        end
      end
`endif
      default: state_d = RST;
    endcase
    // A pending stop converts the next instruction fetch into a halt
    if (boundary) begin
      if (stop_d) begin
        state_d = HALTED;
        stop_d  = 1'b0;
      end else begin
        state_d = NEXT_INSTR;
      end
    end
  end

  // Sequencer state; Reset overrides a simultaneous Stop
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= RST;
      op_q    <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      stop_q  <= stop_d;
    end
  end

  // Moore strobe decode: at most one bus driver per step
  always_comb begin
    PCout  = 1'b0; MARin = 1'b0; IncPC = 1'b0; Zin    = 1'b0;
    ZLOout = 1'b0; ZHIout = 1'b0; PCin = 1'b0; Read   = 1'b0;
    MDRin  = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin    = 1'b0;
    Gra    = 1'b0; Grb   = 1'b0; Grc   = 1'b0; Rin    = 1'b0;
    Rout   = 1'b0; HIin  = 1'b0; LOin  = 1'b0;
    alu_op = '0;
    Run    = (state_q != RST) && (state_q != HALTED);
    case (state_q)
      T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      T1: begin ZLOout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      T2: begin MDRout = 1'b1; IRin = 1'b1; end
      T3: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
      T4: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op_q; end
      T5: begin
        ZLOout = 1'b1;
        if (is_muldiv(op_q)) LOin = 1'b1;
        else begin Gra = 1'b1; Rin = 1'b1; end
      end
      T6: begin ZHIout = 1'b1; HIin = 1'b1; end
      default: ;
    endcase
  end

endmodule
